// File: rtl/q2_pkg.sv
// q2_pkg: state codes and parameter bounds shared by the Q2 sequencer files.
package q2_pkg;
  typedef logic [3:0] state_t;
  localparam state_t ST_FETCH = 4'b0000;
  localparam state_t ST_DEREF = 4'b0001;
  localparam state_t ST_LOAD  = 4'b0010;
  localparam state_t ST_EXEC  = 4'b0011;
  localparam state_t ST_ALU0  = 4'b0100;
  localparam int ALU_STEPS_MAX = 12;
endpackage

// File: rtl/q2_sequencer_if.sv
// q2_seq_if: front-panel/opcode inputs and state/strobe outputs of the Q2 sequencer.
interface q2_seq_if;
  logic run, step, o0, o1, o2;
  logic s0, s1, s2, s3, ws, running, alu_last;
  modport master (input run, step, o0, o1, o2, output s0, s1, s2, s3, ws, running, alu_last);
  modport slave (output run, step, o0, o1, o2, input s0, s1, s2, s3, ws, running, alu_last);
endinterface

// File: rtl/q2_phase_gen.sv
// q2_phase_gen: two-clock settle/strobe phase toggle; ws is the registered phase bit.
module q2_phase_gen (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic ws_o
);
  logic phase_q, phase_d;
  assign phase_d = en_i & ~phase_q;
  always_ff @(posedge clk) phase_q <= rst ? 1'b0 : phase_d;
  assign ws_o = phase_q;
endmodule

// File: rtl/q2_sequencer.sv
// q2_sequencer: machine-state and write-strobe generator for q2_control.
// Define Q2_SEQ_STEP_EN to enable the single-step latch.
module q2_sequencer
  import q2_pkg::*;
#(
  parameter int ALU_STEPS = 8
) (
  input logic clk,
  input logic rst,
  q2_seq_if.master bus
);
  localparam state_t ST_ALU_LAST = state_t'(ST_ALU0 + ALU_STEPS - 1);
  if (ALU_STEPS < 1 || ALU_STEPS > ALU_STEPS_MAX) begin : g_bad_steps
    $error("q2_sequencer: ALU_STEPS out of range 1..12");
  end
  state_t state_q, state_d;
  logic running_q, running_d, alu_last_q, ws, start, done;
`ifdef Q2_SEQ_STEP_EN
  logic step_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.o0, bus.o1};
  assign start = bus.run | step_q;
  // step is only latched while idle; a start by run clears any pending step
  always_ff @(posedge clk) step_q <= rst ? 1'b0 : ~running_q & ~start & bus.step;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.o0, bus.o1, bus.step};
  assign start = bus.run;
`endif
  q2_phase_gen u_phase (.clk(clk), .rst(rst), .en_i(running_q), .ws_o(ws));
  // ALU0 directly follows EXEC in code order, so a plain increment covers o2 = 0
  always_comb begin
    done = running_q & ws & ((state_q == ST_EXEC & bus.o2) | state_q == ST_ALU_LAST);
    running_d = (running_q & ~done) | start;
    state_d = ~running_q ? ST_FETCH : ~ws ? state_q : done ? ST_FETCH : state_q + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      running_q <= 1'b0;
      alu_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      running_q <= running_d;
      alu_last_q <= state_d == ST_ALU_LAST;
    end
  end
  assign {bus.s3, bus.s2, bus.s1, bus.s0} = state_q;
  assign bus.ws = ws;
  assign bus.running = running_q;
  assign bus.alu_last = alu_last_q;
endmodule
